scanline_fetch: RTL and testbench
=================================

Name: scanline_fetch

Overview:
- Producer side of the scanline line-RAM pipeline. It fetches one 8bpp framebuffer line from memory, expands each pixel through a 256-entry 24-bit palette, and writes the RGB pixels into the two-bank line RAM ahead of the VGA scan-out.
- It is triggered by the start_of_line and start_of_frame pulses from the VGA timing block. The scanline_y value comes from the same block.
- Line N is always written to bank N[0], and the scan-out side reads bank scanline_y[0].

Parameters:
- H_PIXELS, 640, visible pixels per line; must be a multiple of 4.
- V_LINES, 480, visible lines per frame.
- ADDR_W, 26, memory byte-address width.
- FIFO_DEPTH, 4, response FIFO entries; this is also the maximum number of outstanding memory reads.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start_of_line  in  1  one-cycle pulse; scanline_y is a visible line about to be displayed
- start_of_frame  in  1  one-cycle pulse; scanline_y == V_LINES
- scanline_y  in  10  current display line, valid when either pulse is high
- fb_base  in  ADDR_W  framebuffer byte base address; sampled on each trigger
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_W  word-aligned byte address of the request
- mem_ack  in  1  request accepted this cycle (only meaningful while mem_req is high)
- mem_rvalid  in  1  read data valid; responses return in request order
- mem_rdata  in  32  four pixels; byte 0 is the leftmost pixel
- pal_we  in  1  palette write strobe
- pal_addr  in  8  palette write index
- pal_wdata  in  24  palette entry, RGB 8:8:8
- lineram_write  out  1  line-RAM write strobe
- lineram_waddr  out  11  {bank, x[9:0]}
- lineram_wdata  out  24  RGB pixel
- line_done  out  1  one-cycle pulse after the last pixel of a line is written
- overrun  out  1  sticky flag: a trigger arrived while the previous fetch was not finished

Behaviour:
- Reset values: all outputs are 0; state is IDLE; FIFO is empty; outstanding count is 0. The palette contents are not reset. The memory system shares this reset, so no responses arrive for pre-reset requests.
- Trigger and target line:
  - start_of_frame sets target line T = 0.
  - start_of_line with scanline_y < V_LINES-1 sets T = scanline_y+1.
  - start_of_line with scanline_y == V_LINES-1 is ignored: no fetch, no overrun.
  - If both pulses are high in the same cycle, start_of_frame wins.
- On trigger, latch T and bank = T[0]. Set line_addr = fb_base + T*H_PIXELS, computed modulo 2^ADDR_W. T*640 may be formed as (T<<9)+(T<<7).
- States:
  - IDLE: on trigger go to FETCH.
  - FETCH: issue requests and write pixels. Go to IDLE with a line_done pulse when H_PIXELS/4 words have been issued and H_PIXELS pixels have been written.
  - DRAIN: discard responses until outstanding == 0, then go to FETCH for the latched new line.
- Request issue:
  - mem_req is high in FETCH while words_issued < H_PIXELS/4 and outstanding + fifo_count < FIFO_DEPTH.
  - mem_addr = line_addr + 4*words_issued.
  - mem_req and mem_addr hold stable until mem_ack. words_issued increments on mem_ack.
- Outstanding counter: increments on mem_ack, decrements on mem_rvalid; both in one cycle means no change.
- FIFO: a mem_rvalid word is pushed into the FIFO. The credit rule guarantees it is never full on push.
- Pixel pipeline, one pixel per cycle:
  - Stage 0: select byte k (0..3) of the FIFO head. Pop after k == 3.
  - Stage 1: registered palette read.
  - Stage 2: registered lineram_write, lineram_waddr = {bank, x}, lineram_wdata = palette[index].
  - Latency from the FIFO head becoming available to the first write is 2 cycles.
  - x runs 0..H_PIXELS-1. line_done pulses the cycle after the write of x = H_PIXELS-1.
- Palette:
  - Single write port; pal_we writes on the clock edge.
  - A read of the same index in the same cycle returns the old data.
- Trigger while in FETCH or DRAIN:
  - Set overrun (sticky until reset) and abort the current line; no further lineram writes for it, and no line_done.
  - Latch the new T, bank and fb_base. Flush the FIFO and the pixel pipeline.
  - If outstanding > 0, go to DRAIN; otherwise go straight to FETCH.
  - A request held un-acked at abort is withdrawn: mem_req drops the next cycle. The memory side must treat an un-acked request as revocable.
- Budget: one line period is 4000 clocks. A nominal fetch needs ≥ 640 cycles plus memory latency, so overrun indicates starved memory.

Test Plan:
- Palette index n = n*0x010101. The framebuffer line y holds bytes (x+y)&0xFF. fb_base = 0x100000. Pulse start_of_frame. Expect 160 requests at 0x100000..0x10027C step 4, writes for addr 0x000..0x27F with wdata = (x&0xFF)*0x010101, and line_done once.
- start_of_line, y=5. Expect first mem_addr 0x100000+6*640 = 0x100F00, bank 0 (waddr 0x000..0x27F), wdata at x=0 is 0x060606.
- start_of_line, y=479. Expect no mem_req, no writes, overrun remains 0.
- Memory latency 20 cycles with mem_ack delayed 3 cycles. Expect outstanding never exceeds 4, mem_addr stable while un-acked, and all 640 pixels correct and in order.
- Second trigger (y=6) while the line is mid-fetch with 3 outstanding. Expect overrun=1, the 3 stale responses discarded, then a full fetch of line 7 into bank 1 (waddr 0x400..0x67F) and a single line_done.
- Reset asserted mid-fetch. Expect mem_req, lineram_write, line_done and overrun all 0 next cycle, and a correct fetch on the following trigger.

Source files
------------

// File: rtl/scanline_fetch_if.sv
// scanline_fetch_if: in-order read bus between the line fetcher (master) and the memory system (slave)
interface scanline_fetch_if #(parameter int ADDR_W = 26) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ack, mem_rvalid, mem_rdata);
  modport slave (input mem_req, mem_addr, output mem_ack, mem_rvalid, mem_rdata);
endinterface

// File: rtl/scanline_fetch.sv
// scanline_fetch: fetches one 8bpp framebuffer line, expands it through the palette and fills the line RAM
module scanline_fetch #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int ADDR_W     = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_of_line,
  input  logic              start_of_frame,
  input  logic [9:0]        scanline_y,
  input  logic [ADDR_W-1:0] fb_base,
  scanline_fetch_if.master  mem,
  input  logic              pal_we,
  input  logic [7:0]        pal_addr,
  input  logic [23:0]       pal_wdata,
  output logic              lineram_write,
  output logic [10:0]       lineram_waddr,
  output logic [23:0]       lineram_wdata,
  output logic              line_done,
  output logic              overrun
);
  localparam int WORDS = H_PIXELS / 4;
  localparam int WW = $clog2(WORDS + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] words_q;
  logic [CW-1:0] out_q, out_d, cnt_q;
  logic [PW-1:0] wp_q, rp_q;
  logic [1:0] k_q;
  logic [9:0] x0_q, s1_x_q, t;
  logic [ADDR_W-1:0] line_addr_q;
  logic [31:0] fifo_q [FIFO_DEPTH];
  logic [23:0] pal_mem [256];
  logic [23:0] pal_q, wdata_q;
  logic [10:0] waddr_q;
  logic [7:0] idx;
  logic bank_q, s1_v_q, we_q, line_done_q, line_done_d, overrun_q;
  logic trig, ack, push, fire, pop, done;
  assign trig = start_of_frame | (start_of_line & (scanline_y < 10'(V_LINES - 1)));
  assign t = start_of_frame ? 10'd0 : scanline_y + 10'd1;
  assign ack = mem.mem_req & mem.mem_ack;
  assign push = mem.mem_rvalid & (state_q == FETCH) & ~trig;
  assign fire = (state_q == FETCH) & ~trig & (cnt_q != '0);
  assign pop = fire & (k_q == 2'd3);
  assign out_d = out_q + CW'(ack) - CW'(mem.mem_rvalid);
  assign idx = fifo_q[rp_q][{k_q, 3'b000} +: 8];
  assign done = (state_q == FETCH) & (words_q == WW'(WORDS)) & we_q & (waddr_q[9:0] == 10'(H_PIXELS - 1));
  always_ff @(posedge clock) state_q <= reset ? IDLE : state_d;
  // A trigger always restarts; responses still in flight must drain before the new line can issue
  always_comb
    state_d = trig ? (out_d != '0 ? DRAIN : FETCH) :
              done ? IDLE :
              (state_q == DRAIN && out_q == '0) ? FETCH : state_q;
  always_comb begin
    mem.mem_req = (state_q == FETCH) && (words_q < WW'(WORDS)) &&
                  (({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH));
    mem.mem_addr = line_addr_q + ADDR_W'({words_q, 2'b00});
    line_done_d = done & ~trig;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      words_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      k_q <= '0;
      x0_q <= '0;
      s1_v_q <= 1'b0;
      s1_x_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      line_done_q <= 1'b0;
      overrun_q <= 1'b0;
      bank_q <= 1'b0;
      line_addr_q <= '0;
    end else begin
      out_q <= out_d;
      line_done_q <= line_done_d;
      overrun_q <= overrun_q | (trig & (state_q != IDLE));
      s1_v_q <= fire;
      s1_x_q <= x0_q;
      we_q <= s1_v_q & ~trig;
      waddr_q <= {bank_q, s1_x_q};
      wdata_q <= pal_q;
      if (trig) begin
        bank_q <= t[0];
        line_addr_q <= fb_base + ADDR_W'(t) * ADDR_W'(H_PIXELS);
        words_q <= '0;
        cnt_q <= '0;
        wp_q <= '0;
        rp_q <= '0;
        k_q <= '0;
        x0_q <= '0;
      end else begin
        words_q <= words_q + WW'(ack);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
        wp_q <= wp_q + PW'(push);
        rp_q <= rp_q + PW'(pop);
        k_q <= k_q + 2'(fire);
        x0_q <= x0_q + 10'(fire);
      end
    end
  end
  // Storage arrays are not reset; a same-cycle palette write is seen by the next read only
  always_ff @(posedge clock) begin
    pal_q <= pal_mem[idx];
    if (pal_we) pal_mem[pal_addr] <= pal_wdata;
    if (push) fifo_q[wp_q] <= mem.mem_rdata;
  end
  assign lineram_write = we_q;
  assign lineram_waddr = waddr_q;
  assign lineram_wdata = wdata_q;
  assign line_done = line_done_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_scanline_fetch.sv
// tb_scanline_fetch: directed checks of line fetch, palette expansion, abort/drain and reset
module tb_scanline_fetch;
  logic clock = 0, reset = 1, start_of_line = 0, start_of_frame = 0, pal_we = 0;
  logic [9:0] scanline_y = 0;
  logic [25:0] fb_base = 0;
  logic [7:0] pal_addr = 0;
  logic [23:0] pal_wdata = 0;
  logic lineram_write, line_done, overrun;
  logic [10:0] lineram_waddr;
  logic [23:0] lineram_wdata;
  scanline_fetch_if #(.ADDR_W(26)) mif ();
  scanline_fetch dut (
    .clock(clock), .reset(reset), .start_of_line(start_of_line), .start_of_frame(start_of_frame),
    .scanline_y(scanline_y), .fb_base(fb_base), .mem(mif), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .lineram_write(lineram_write), .lineram_waddr(lineram_waddr),
    .lineram_wdata(lineram_wdata), .line_done(line_done), .overrun(overrun)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_fail = 0;
  int pal_mode = 0, lat = 1, ack_dly = 0, cyc = 0, wait_cnt = 0, tb_out = 0, max_out = 0;
  bit ack_en = 1, prev_held = 0;
  int exp_y = 0, req_cnt = 0, req_bad = 0, wr_cnt = 0, wr_bad = 0, done_cnt = 0, unstable = 0, req_cycles = 0;
  logic [31:0] exp_base = 0, mem_base = 0, first_addr = 0, first_wdata = 0, first_waddr = 0, prev_addr = 0;
  int q_due[$];
  logic [31:0] q_addr[$];
  function automatic logic [23:0] pal_model(input int mode, input int n);
    logic [7:0] b;
    b = 8'(n);
    return mode == 0 ? {b, b, b} : {b, ~b, b ^ 8'h5A};
  endfunction
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off, w;
    int line, x;
    off = (a - mem_base) & 32'h03FF_FFFF;
    line = int'(off / 640);
    x = int'(off % 640);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(x + i + line);
    return w;
  endfunction
  // Memory model and write/request monitor, both acting away from the DUT's clock edge
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      q_due.delete();
      q_addr.delete();
      mif.mem_ack = 0;
      mif.mem_rvalid = 0;
      mif.mem_rdata = 0;
      tb_out = 0;
      wait_cnt = 0;
      prev_held = 0;
    end else begin
      mif.mem_ack = mif.mem_req && ack_en && wait_cnt >= ack_dly;
      wait_cnt = (mif.mem_req && !mif.mem_ack) ? wait_cnt + 1 : 0;
      mif.mem_rvalid = 0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        mif.mem_rvalid = 1;
        mif.mem_rdata = mem_word(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (mif.mem_ack) begin
        q_due.push_back(cyc + lat);
        q_addr.push_back(32'(mif.mem_addr));
      end
      tb_out += int'(mif.mem_ack) - int'(mif.mem_rvalid);
      if (tb_out > max_out) max_out = tb_out;
      if (mif.mem_req) req_cycles++;
      if (mif.mem_req && prev_held && 32'(mif.mem_addr) != prev_addr) unstable++;
      prev_held = mif.mem_req && !mif.mem_ack;
      prev_addr = 32'(mif.mem_addr);
      if (mif.mem_ack) begin
        if (req_cnt == 0) first_addr = 32'(mif.mem_addr);
        if (32'(mif.mem_addr) != ((exp_base + 32'(exp_y) * 640 + 32'(req_cnt) * 4) & 32'h03FF_FFFF)) req_bad++;
        req_cnt++;
      end
      if (lineram_write) begin
        if (wr_cnt == 0) begin
          first_waddr = 32'(lineram_waddr);
          first_wdata = 32'(lineram_wdata);
        end
        if (32'(lineram_waddr) != 32'((exp_y % 2) * 1024 + wr_cnt) ||
            lineram_wdata != pal_model(pal_mode, wr_cnt + exp_y)) wr_bad++;
        wr_cnt++;
      end
      if (line_done) done_cnt++;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask
  task automatic load_palette(input int mode);
    pal_mode = mode;
    for (int n = 0; n < 256; n++) begin
      pal_we = 1;
      pal_addr = 8'(n);
      pal_wdata = pal_model(mode, n);
      step(1);
    end
    pal_we = 0;
  endtask
  task automatic trig(input logic sof, input logic sol, input logic [9:0] y, input logic [31:0] base, input int line);
    fb_base = base[25:0];
    start_of_frame = sof;
    start_of_line = sol;
    scanline_y = y;
    exp_y = line;
    exp_base = base;
    mem_base = base;
    req_cnt = 0;
    req_bad = 0;
    wr_cnt = 0;
    wr_bad = 0;
    done_cnt = 0;
    unstable = 0;
    max_out = 0;
    req_cycles = 0;
    first_addr = 32'hDEAD_BEEF;
    first_waddr = 32'hDEAD_BEEF;
    first_wdata = 32'hDEAD_BEEF;
    step(1);
    start_of_frame = 0;
    start_of_line = 0;
  endtask
  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      step(1);
      i++;
    end
    check($sformatf("%s line_done_in_budget", tag), 32'(done_cnt != 0), 1);
    step(10);
  endtask
  task automatic line_checks(input string tag, input logic [31:0] fa, input logic [31:0] fw, input logic [31:0] fd);
    check($sformatf("%s first_mem_addr", tag), first_addr, fa);
    check($sformatf("%s first_waddr", tag), first_waddr, fw);
    check($sformatf("%s first_wdata", tag), first_wdata, fd);
    check($sformatf("%s req_count", tag), 32'(req_cnt), 160);
    check($sformatf("%s req_addr_errors", tag), 32'(req_bad), 0);
    check($sformatf("%s write_count", tag), 32'(wr_cnt), 640);
    check($sformatf("%s write_errors", tag), 32'(wr_bad), 0);
    check($sformatf("%s line_done_count", tag), 32'(done_cnt), 1);
  endtask
  initial begin
    mif.mem_ack = 0;
    mif.mem_rvalid = 0;
    mif.mem_rdata = 0;
    step(3);
    check("reset mem_req", 32'(mif.mem_req), 0);
    check("reset lineram_write", 32'(lineram_write), 0);
    check("reset lineram_waddr", 32'(lineram_waddr), 0);
    check("reset lineram_wdata", 32'(lineram_wdata), 0);
    check("reset line_done", 32'(line_done), 0);
    check("reset overrun", 32'(overrun), 0);
    reset = 0;
    load_palette(0);
    trig(1, 0, 10'd480, 32'h0010_0000, 0);
    wait_done("frame", 4000);
    line_checks("frame", 32'h0010_0000, 0, 0);
    check("frame overrun", 32'(overrun), 0);
    trig(0, 1, 10'd5, 32'h0010_0000, 6);
    wait_done("y5", 4000);
    line_checks("y5", 32'h0010_0F00, 0, 32'h0006_0606);
    trig(0, 1, 10'd479, 32'h0010_0000, 480);
    step(50);
    check("y479 req_cycles", 32'(req_cycles), 0);
    check("y479 writes", 32'(wr_cnt), 0);
    check("y479 line_done", 32'(done_cnt), 0);
    check("y479 overrun", 32'(overrun), 0);
    trig(1, 1, 10'd10, 32'h0010_0000, 0);
    wait_done("both", 4000);
    line_checks("both", 32'h0010_0000, 0, 0);
    load_palette(1);
    lat = 20;
    ack_dly = 3;
    trig(0, 1, 10'd100, 32'h0010_0000, 101);
    wait_done("slow", 4000);
    line_checks("slow", 32'h0010_FC80, 32'h400, 32'h0065_9A3F);
    check("slow max_outstanding_le4", 32'(max_out <= 4), 1);
    check("slow addr_stable", 32'(unstable), 0);
    check("slow overrun", 32'(overrun), 0);
    lat = 30;
    ack_dly = 0;
    trig(0, 1, 10'd5, 32'h0010_0000, 6);
    for (int i = 0; i < 100 && tb_out != 3; i++) step(1);
    check("abort outstanding_before", 32'(tb_out), 3);
    ack_en = 0;
    trig(0, 1, 10'd6, 32'h0010_0000, 7);
    check("abort overrun", 32'(overrun), 1);
    check("abort req_withdrawn", 32'(mif.mem_req), 0);
    ack_en = 1;
    wait_done("abort", 4000);
    line_checks("abort", 32'h0010_1180, 32'h400, 32'h0007_F85D);
    check("abort outstanding_after", 32'(tb_out), 0);
    check("abort overrun_sticky", 32'(overrun), 1);
    lat = 1;
    trig(1, 0, 10'd480, 32'h0010_0000, 0);
    step(100);
    reset = 1;
    step(1);
    check("midreset mem_req", 32'(mif.mem_req), 0);
    check("midreset lineram_write", 32'(lineram_write), 0);
    check("midreset line_done", 32'(line_done), 0);
    check("midreset overrun", 32'(overrun), 0);
    reset = 0;
    step(1);
    trig(0, 1, 10'd2, 32'h03FF_FE00, 3);
    wait_done("wrap", 4000);
    line_checks("wrap", 32'h0000_0580, 32'h400, 32'h0003_FC59);
    check("wrap overrun", 32'(overrun), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
